// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the game tick scheduler: state encoding
// and the default prescale / channel period used at the top level.
package game_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam int DEF_PRESCALE = 25000;
    localparam int DEF_PERIOD   = 1;

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: counts base-tick terminal events and
// emits a one-cycle strobe every 'period' events; period 0 disables it.
module tick_channel #(
    parameter int DW         = 8,
    parameter int DEF_PERIOD = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          terminal_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_period_i,
    output logic          tick_o
);

    logic [DW-1:0] period_q, period_d;
    logic [DW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    // Next-state: a write always wins over a coincident terminal event.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        if (wr_i) begin
            period_d = wr_period_i;
            count_d  = '0;
        end else if (clear_i) begin
            count_d = '0;
        end else if (terminal_i && (period_q != '0)) begin
            if (count_q == (period_q - DW'(1))) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + DW'(1);
            end
        end
    end

    // Channel registers with synchronous reset to the default period.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            period_q <= DW'(DEF_PERIOD);
            count_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: prescales clk into a base tick and fans it out to
// NCH programmable clock-enable channels under run/pause/stop control.
module game_tick_scheduler #(
    parameter int PRESCALE   = game_timing_pkg::DEF_PRESCALE,
    parameter int PW         = 16,
    parameter int NCH        = 4,
    parameter int CW         = 2,
    parameter int DW         = 8,
    parameter int DEF_PERIOD = game_timing_pkg::DEF_PERIOD
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           stop_i,
    input  logic           pause_i,
    input  logic           cfg_we_i,
    input  logic [CW-1:0]  cfg_ch_i,
    input  logic [DW-1:0]  cfg_period_i,
    output logic           cfg_ack_o,
    output logic           base_tick_o,
    output logic [NCH-1:0] ch_tick_o,
    output logic           running_o,
    output logic           paused_o
);

    game_timing_pkg::state_e state_q, state_d;

    logic [PW-1:0] presc_q, presc_d;
    logic          base_tick_q, base_tick_d;
    logic          cfg_ack_q, cfg_ack_d;
    logic          terminal;
    logic          clear;

    // Next state, prescaler step and terminal detection; counters act on
    // the registered state, so a transition only affects the next cycle.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        terminal    = 1'b0;
        clear       = 1'b0;
        cfg_ack_d   = cfg_we_i;

        if (stop_i) begin
            state_d = game_timing_pkg::ST_IDLE;
        end else begin
            case (state_q)
                game_timing_pkg::ST_IDLE:   if (start_i)  state_d = game_timing_pkg::ST_RUN;
                game_timing_pkg::ST_RUN:    if (pause_i)  state_d = game_timing_pkg::ST_PAUSED;
                game_timing_pkg::ST_PAUSED: if (!pause_i) state_d = game_timing_pkg::ST_RUN;
                default:                    state_d = game_timing_pkg::ST_IDLE;
            endcase
        end

        case (state_q)
            game_timing_pkg::ST_RUN: begin
                if (presc_q == PW'(PRESCALE - 1)) begin
                    presc_d  = '0;
                    terminal = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            game_timing_pkg::ST_PAUSED: presc_d = presc_q;
            default: begin
                presc_d = '0;
                clear   = 1'b1;
            end
        endcase

        base_tick_d = terminal;
    end

    // State, prescaler and strobe registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= game_timing_pkg::ST_IDLE;
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    // Writes to channel numbers at or above NCH match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .DW         (DW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .clear_i     (clear),
            .terminal_i  (terminal),
            .wr_i        (cfg_we_i && (cfg_ch_i == CW'(i))),
            .wr_period_i (cfg_period_i),
            .tick_o      (ch_tick_o[i])
        );
    end

    assign base_tick_o = base_tick_q;
    assign cfg_ack_o   = cfg_ack_q;
    assign running_o   = (state_q == game_timing_pkg::ST_RUN);
    assign paused_o    = (state_q == game_timing_pkg::ST_PAUSED);

endmodule
